rs_flash_sequencer: RTL

- Command sequencer between the RS byte link and the 8-bit flash port.
- Pulls a 2- or 3-byte command from the RS receiver, runs one flash read or write, and returns a 1-byte reply over the RS transmitter.
- Sits under the top-level manager and owns all RS_* and FL_* control strobes; one command is in flight at a time.

---
 rtl/rs_flash_sequencer_pkg.sv | 35 +++
 rtl/rs_flash_sequencer_flash_busy_watchdog.sv | 42 ++++
 rtl/rs_flash_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rs_flash_sequencer_pkg.sv
// Shared definitions for the RS-link / flash-port command sequencer:
// state encoding, opcode and reply constants, and the flash address reset value.
package rs_flash_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RX_OP,
        ST_RX_ADDR,
        ST_RX_DATA,
        ST_FL_ARM,
        ST_FL_HOLD,
        ST_FL_WAIT,
        ST_TX,
        ST_TX_WAIT
    } state_e;

    localparam logic [7:0] OP_READ_DEF   = 8'h52;  // 'R'
    localparam logic [7:0] OP_WRITE_DEF  = 8'h57;  // 'W'

    localparam logic [7:0] REPLY_ACK     = 8'h4B;
    localparam logic [7:0] REPLY_BADOP   = 8'h3F;
    localparam logic [7:0] REPLY_TIMEOUT = 8'hEE;

    localparam logic [7:0] FL_ADDR_RST   = 8'hCC;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    // True when the received opcode names a command this block executes.
    function automatic logic is_known_op(input logic [7:0] op,
                                         input logic [7:0] op_rd,
                                         input logic [7:0] op_wr);
        return (op == op_rd) || (op == op_wr);
    endfunction

endpackage

// File: rtl/rs_flash_sequencer_flash_busy_watchdog.sv
// Flash busy watchdog: counts cycles spent waiting on the flash and flags
// expiry. Only built when FLASH_TIMEOUT_EN is defined.
`ifdef FLASH_TIMEOUT_EN
module flash_busy_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    // Expiry fires in the cycle whose closing edge would bring the count to
    // TIMEOUT_CYCLES, so the waiting state lasts exactly TIMEOUT_CYCLES clocks.
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    // Next count: clear on state entry, otherwise advance while enabled, saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LIMIT);

endmodule
`endif

// File: rtl/rs_flash_sequencer.sv
// Command sequencer between the RS byte link and the 8-bit flash port.
// Receives a 2- or 3-byte command, performs one flash read or write and
// returns a 1-byte reply. Optional flash busy timeout: define FLASH_TIMEOUT_EN.
module rs_flash_sequencer
    import rs_flash_sequencer_pkg::*;
#(
    parameter logic [7:0]  OP_READ        = OP_READ_DEF,
    parameter logic [7:0]  OP_WRITE       = OP_WRITE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    output logic       RS_FLOW,
    output logic [7:0] RS_DATAIN,
    input  logic [7:0] RS_DATAOUT,
    output logic       RS_TRG_READ,
    output logic       RS_TRG_WRITE,
    input  logic       RS_DONE,
    inout  wire  [7:0] FL_DATA,
    output logic [7:0] FL_ADDR,
    output logic       FL_TRG,
    input  logic       FL_STATUS,
    output logic       FL_FLOW
);

    state_e     state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] reply_q, reply_d;

    logic       rs_flow_q, rs_flow_d;
    logic [7:0] rs_datain_q, rs_datain_d;
    logic       rs_trg_read_q, rs_trg_read_d;
    logic       rs_trg_write_q, rs_trg_write_d;
    logic [7:0] fl_addr_q, fl_addr_d;
    logic [7:0] fl_dout_q, fl_dout_d;
    logic       fl_trg_q, fl_trg_d;
    logic       fl_flow_q, fl_flow_d;

    logic       wd_expired;
    logic       is_write;

    assign is_write = (op_q == OP_WRITE);

`ifdef FLASH_TIMEOUT_EN
    logic wd_en;
    logic wd_clr;

    assign wd_en  = (state_q == ST_FL_ARM) || (state_q == ST_FL_WAIT);
    assign wd_clr = (state_d != state_q);

    flash_busy_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (CLK_50MHZ),
        .rst_ni    (RST),
        .en_i      (wd_en),
        .clr_i     (wd_clr),
        .expired_o (wd_expired)
    );
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    // Next-state and registered-output logic; trigger strobes default low so they pulse.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        data_d         = data_q;
        reply_d        = reply_q;
        rs_flow_d      = rs_flow_q;
        rs_datain_d    = rs_datain_q;
        rs_trg_read_d  = 1'b0;
        rs_trg_write_d = 1'b0;
        fl_addr_d      = fl_addr_q;
        fl_dout_d      = fl_dout_q;
        fl_trg_d       = 1'b0;
        fl_flow_d      = fl_flow_q;

        case (state_q)
            ST_IDLE: begin
                rs_flow_d     = 1'b0;
                rs_trg_read_d = 1'b1;
                state_d       = ST_RX_OP;
            end
            ST_RX_OP: begin
                if (RS_DONE) begin
                    op_d = RS_DATAOUT;
                    if (is_known_op(RS_DATAOUT, OP_READ, OP_WRITE)) begin
                        rs_trg_read_d = 1'b1;
                        state_d       = ST_RX_ADDR;
                    end else begin
                        reply_d = REPLY_BADOP;
                        state_d = ST_TX;
                    end
                end
            end
            ST_RX_ADDR: begin
                if (RS_DONE) begin
                    addr_d = RS_DATAOUT;
                    if (is_write) begin
                        rs_trg_read_d = 1'b1;
                        state_d       = ST_RX_DATA;
                    end else begin
                        state_d = ST_FL_ARM;
                    end
                end
            end
            ST_RX_DATA: begin
                if (RS_DONE) begin
                    data_d  = RS_DATAOUT;
                    state_d = ST_FL_ARM;
                end
            end
            ST_FL_ARM: begin
                if (!FL_STATUS) begin
                    fl_addr_d = addr_q;
                    fl_flow_d = is_write;
                    fl_dout_d = data_q;
                    fl_trg_d  = 1'b1;
                    state_d   = ST_FL_HOLD;
                end else if (wd_expired) begin
                    reply_d   = REPLY_TIMEOUT;
                    fl_flow_d = 1'b0;
                    state_d   = ST_TX;
                end
            end
            ST_FL_HOLD: begin
                // The flash raises busy one cycle after the trigger; skip that cycle.
                state_d = ST_FL_WAIT;
            end
            ST_FL_WAIT: begin
                if (!FL_STATUS) begin
                    reply_d   = is_write ? REPLY_ACK : FL_DATA;
                    fl_flow_d = 1'b0;
                    state_d   = ST_TX;
                end else if (wd_expired) begin
                    reply_d   = REPLY_TIMEOUT;
                    fl_flow_d = 1'b0;
                    state_d   = ST_TX;
                end
            end
            ST_TX: begin
                rs_flow_d      = 1'b1;
                rs_datain_d    = reply_q;
                rs_trg_write_d = 1'b1;
                state_d        = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (RS_DONE) begin
                    rs_flow_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any command and releases the flash bus.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state_q        <= ST_IDLE;
            op_q           <= 8'h00;
            addr_q         <= 8'h00;
            data_q         <= 8'h00;
            reply_q        <= 8'h00;
            rs_flow_q      <= 1'b0;
            rs_datain_q    <= 8'h00;
            rs_trg_read_q  <= 1'b0;
            rs_trg_write_q <= 1'b0;
            fl_addr_q      <= FL_ADDR_RST;
            fl_dout_q      <= 8'h00;
            fl_trg_q       <= 1'b0;
            fl_flow_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            reply_q        <= reply_d;
            rs_flow_q      <= rs_flow_d;
            rs_datain_q    <= rs_datain_d;
            rs_trg_read_q  <= rs_trg_read_d;
            rs_trg_write_q <= rs_trg_write_d;
            fl_addr_q      <= fl_addr_d;
            fl_dout_q      <= fl_dout_d;
            fl_trg_q       <= fl_trg_d;
            fl_flow_q      <= fl_flow_d;
        end
    end

    assign RS_FLOW      = rs_flow_q;
    assign RS_DATAIN    = rs_datain_q;
    assign RS_TRG_READ  = rs_trg_read_q;
    assign RS_TRG_WRITE = rs_trg_write_q;
    assign FL_ADDR      = fl_addr_q;
    assign FL_TRG       = fl_trg_q;
    assign FL_FLOW      = fl_flow_q;
    assign FL_DATA      = fl_flow_q ? fl_dout_q : 8'hzz;

endmodule
